yuv_stream_packer: RTL and testbench

Synthesizable front end that accepts the CCIR601-style interleaved 4:2:2 byte stream (Y, Cb, Y, Cr, one byte per strobe) and packs it into 32-bit words for the external dual-port frame RAM. Luma and chroma are packed into separate regions of a double-buffered frame bank. The block generalises the stream format with parametrised frame size and address width, and adds a run-time 4:2:0 mode that drops odd-line chroma. It sits between the video input pins and the frame memory write port in front of FrametoMacroBlock, and flags macroblock-row and frame completion for the motion-detection scheduler.

---
 rtl/yuv_stream_packer.sv | 175 +++++++++++++++++
 tb/tb_yuv_stream_packer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv_stream_packer.sv
// yuv_stream_packer: packs an interleaved 4:2:2 byte stream (Y,Cb,Y,Cr)
// into 32-bit words. Luma and chroma go to separate regions of a
// double-buffered frame bank.
//
// Ports:
//   clk, rst (async, active-low)
//   ena, dclr, dstrb, din1[7:0], mode420          -- stream side
//   wr_en, wr_addr[ADDR_W-1:0], wr_data[31:0]      -- RAM write port
//   mbrow_done, mbrow[5:0], frame_done, bank       -- scheduler status
module yuv_stream_packer #(
    parameter int FRAME_WIDTH  = 144,
    parameter int FRAME_HEIGHT = 80,
    parameter int ADDR_W       = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              dclr,
    input  logic              dstrb,
    input  logic [7:0]        din1,
    input  logic              mode420,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              mbrow_done,
    output logic [5:0]        mbrow,
    output logic              frame_done,
    output logic              bank
);

    localparam int XW = $clog2(FRAME_WIDTH);
    localparam int YW = $clog2(FRAME_HEIGHT);
    localparam int OW = ADDR_W - 1;

    localparam logic [OW-1:0] WQ    = OW'(FRAME_WIDTH / 4);
    localparam logic [OW-1:0] CBASE = OW'(FRAME_WIDTH * FRAME_HEIGHT / 4);
    localparam logic [XW-1:0] XLAST = XW'(FRAME_WIDTH - 2);
    localparam logic [YW-1:0] YLAST = YW'(FRAME_HEIGHT - 1);

    logic [1:0]        p_q, p_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [31:0]       luma_q, luma_d;
    logic [31:0]       chroma_q, chroma_d;
    logic              mode_q, mode_d;
    logic              bank_q, bank_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              mbrow_done_q, mbrow_done_d;
    logic [5:0]        mbrow_q, mbrow_d;
    logic              frame_done_q, frame_done_d;

    logic          skip_c;
    logic [YW-1:0] cl;
    logic [OW-1:0] luma_off;
    logic [OW-1:0] chroma_off;
    logic          line_end;
    logic          frame_end;

    // Odd lines in 4:2:0 mode carry chroma that is consumed but never stored.
    assign skip_c     = mode_q & y_q[0];
    assign cl         = mode_q ? (y_q >> 1) : y_q;
    assign luma_off   = OW'(y_q) * WQ + OW'(x_q >> 2);
    assign chroma_off = CBASE + OW'(cl) * WQ + OW'(x_q >> 2);
    assign line_end   = (x_q == XLAST);
    assign frame_end  = line_end && (y_q == YLAST);

    always_comb begin
        p_d          = p_q;
        x_d          = x_q;
        y_d          = y_q;
        luma_d       = luma_q;
        chroma_d     = chroma_q;
        mode_d       = mode_q;
        bank_d       = bank_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        mbrow_done_d = 1'b0;
        mbrow_d      = mbrow_q;
        frame_done_d = 1'b0;
        if (ena && dclr) begin
            p_d      = '0;
            x_d      = '0;
            y_d      = '0;
            luma_d   = '0;
            chroma_d = '0;
            mode_d   = mode420;
        end else if (ena && dstrb) begin
            p_d = p_q + 2'd1;
            unique case (p_q)
                2'd0: luma_d = {din1, luma_q[31:8]};
                2'd1: begin
                    if (!skip_c) chroma_d = {din1, chroma_q[31:8]};
                end
                2'd2: begin
                    luma_d = {din1, luma_q[31:8]};
                    // second pixel pair of a 4-pixel group completes the word
                    if (x_q[1]) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {bank_q, luma_off};
                        wr_data_d = luma_d;
                    end
                end
                2'd3: begin
                    if (!skip_c) begin
                        chroma_d = {din1, chroma_q[31:8]};
                        if (x_q[1]) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = {bank_q, chroma_off};
                            wr_data_d = chroma_d;
                        end
                    end
                    if (line_end) begin
                        x_d          = '0;
                        mbrow_done_d = (y_q[3:0] == 4'hf);
                        if (y_q[3:0] == 4'hf) mbrow_d = 6'(y_q >> 4);
                        frame_done_d = frame_end;
                        if (frame_end) begin
                            y_d    = '0;
                            bank_d = ~bank_q;
                            mode_d = mode420;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(2);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            luma_q       <= '0;
            chroma_q     <= '0;
            mode_q       <= 1'b0;
            bank_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            mbrow_done_q <= 1'b0;
            mbrow_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            x_q          <= x_d;
            y_q          <= y_d;
            luma_q       <= luma_d;
            chroma_q     <= chroma_d;
            mode_q       <= mode_d;
            bank_q       <= bank_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            mbrow_done_q <= mbrow_done_d;
            mbrow_q      <= mbrow_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign mbrow_done = mbrow_done_q;
    assign mbrow      = mbrow_q;
    assign frame_done = frame_done_q;
    assign bank       = bank_q;

endmodule

// File: tb/tb_yuv_stream_packer.sv
// Bench for yuv_stream_packer at 16x16: vector table plus
// line-level stream sequences checked through an expectation queue.
module tb_yuv_stream_packer;

    logic        clk, rst, ena, dclr, dstrb, mode420;
    logic [7:0]  din1;
    logic        wr_en, mbrow_done, frame_done, bank;
    logic [16:0] wr_addr;
    logic [31:0] wr_data;
    logic [5:0]  mbrow;

    yuv_stream_packer #(
        .FRAME_WIDTH(16), .FRAME_HEIGHT(16), .ADDR_W(17)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .dclr(dclr), .dstrb(dstrb),
        .din1(din1), .mode420(mode420), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .mbrow_done(mbrow_done), .mbrow(mbrow),
        .frame_done(frame_done), .bank(bank)
    );

    typedef struct {
        logic        wr;
        logic [16:0] addr;
        logic [31:0] data;
        logic        mbd;
        logic [5:0]  mr;
        logic        fd;
        logic        bk;
        int          due;
    } exp_t;

    typedef struct {
        logic [7:0]  din;
        logic        wr;
        logic [16:0] addr;
        logic [31:0] data;
    } vec_t;

    exp_t q[$];
    vec_t tbl[8];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && (wr_en || mbrow_done || frame_done)) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected output: wr_en=%0b addr=%0h mbd=%0b fd=%0b",
                         wr_en, wr_addr, mbrow_done, frame_done);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("latency", 64'(cyc), 64'(e.due));
                check("wr_en", 64'(wr_en), 64'(e.wr));
                if (e.wr) begin
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", 64'(wr_data), 64'(e.data));
                end
                check("mbrow_done", 64'(mbrow_done), 64'(e.mbd));
                if (e.mbd) check("mbrow", 64'(mbrow), 64'(e.mr));
                check("frame_done", 64'(frame_done), 64'(e.fd));
                check("bank", 64'(bank), 64'(e.bk));
            end
        end
    end

    task automatic strobe(input logic [7:0] b, input logic wr,
                          input logic [16:0] a, input logic [31:0] d,
                          input logic mbd, input logic [5:0] mr,
                          input logic fd, input logic bk);
        exp_t e;
        @(negedge clk);
        dstrb = 1'b1;
        din1  = b;
        if (wr || mbd || fd) begin
            e.wr = wr; e.addr = a; e.data = d; e.mbd = mbd;
            e.mr = mr; e.fd = fd; e.bk = bk; e.due = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
        dstrb = 1'b0;
    endtask

    task automatic drain(input string nm);
        repeat (3) @(negedge clk);
        check(nm, 64'(q.size()), 64'd0);
    endtask

    task automatic do_dclr(input logic m);
        @(negedge clk);
        dclr    = 1'b1;
        mode420 = m;
        @(negedge clk);
        dclr    = 1'b0;
        mode420 = 1'b0;
    endtask

    task automatic run_table(input int gap_at);
        for (int i = 0; i < 8; i++) begin
            if (i == gap_at) begin
                @(negedge clk);
                ena = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    dstrb = ~dstrb;
                    din1  = 8'hEE;
                end
                dstrb = 1'b0;
                @(negedge clk);
                ena = 1'b1;
            end
            strobe(tbl[i].din, tbl[i].wr, tbl[i].addr, tbl[i].data,
                   1'b0, 6'd0, 1'b0, 1'b0);
        end
    endtask

    function automatic logic [7:0] lum(input int y, input int x);
        return 8'(y * 16 + x);
    endfunction
    function automatic logic [7:0] cb(input int y, input int x);
        return 8'(8'h80 + y * 5 + x);
    endfunction
    function automatic logic [7:0] cr(input int y, input int x);
        return 8'(8'hC1 + y * 3 + x * 2);
    endfunction

    task automatic send_line(input int y, input bit m420, input bit bk);
        for (int x = 0; x < 16; x += 2) begin
            bit lw, cw, last, mbd, fd;
            int cl;
            lw   = (x % 4 == 2);
            cw   = (x % 4 == 2) && !(m420 && (y % 2 == 1));
            cl   = m420 ? y / 2 : y;
            last = (x == 14);
            mbd  = last && (y % 16 == 15);
            fd   = last && (y == 15);
            strobe(lum(y, x), 1'b0, '0, '0, 1'b0, 6'd0, 1'b0, bk);
            strobe(cb(y, x), 1'b0, '0, '0, 1'b0, 6'd0, 1'b0, bk);
            strobe(lum(y, x + 1), lw, {bk, 16'(y * 4 + x / 4)},
                   {lum(y, x + 1), lum(y, x), lum(y, x - 1), lum(y, x - 2)},
                   1'b0, 6'd0, 1'b0, bk);
            strobe(cr(y, x), cw, {bk, 16'(64 + cl * 4 + x / 4)},
                   {cr(y, x), cb(y, x), cr(y, x - 2), cb(y, x - 2)},
                   mbd, 6'(y / 16), fd, fd ? ~bk : bk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{8'h00, 1'b0, 17'h0, 32'h0};
        tbl[1] = '{8'h80, 1'b0, 17'h0, 32'h0};
        tbl[2] = '{8'h01, 1'b0, 17'h0, 32'h0};
        tbl[3] = '{8'h90, 1'b0, 17'h0, 32'h0};
        tbl[4] = '{8'h02, 1'b0, 17'h0, 32'h0};
        tbl[5] = '{8'h81, 1'b0, 17'h0, 32'h0};
        tbl[6] = '{8'h03, 1'b1, 17'd0, 32'h03020100};
        tbl[7] = '{8'h91, 1'b1, 17'd64, 32'h91819080};

        rst = 1'b0; ena = 1'b1; dclr = 1'b0; dstrb = 1'b0;
        din1 = 8'h00; mode420 = 1'b0;
        #1;
        check("rst wr_en", 64'(wr_en), 64'd0);
        check("rst wr_addr", 64'(wr_addr), 64'd0);
        check("rst wr_data", 64'(wr_data), 64'd0);
        check("rst mbrow_done", 64'(mbrow_done), 64'd0);
        check("rst mbrow", 64'(mbrow), 64'd0);
        check("rst frame_done", 64'(frame_done), 64'd0);
        check("rst bank", 64'(bank), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // basic packing
        run_table(-1);
        drain("drain packing");

        // ena low mid-word
        do_dclr(1'b0);
        run_table(2);
        drain("drain ena");

        // dclr after 6 bytes discards partials
        do_dclr(1'b0);
        for (int i = 0; i < 6; i++)
            strobe(8'h55 + 8'(i), 1'b0, '0, '0, 1'b0, 6'd0, 1'b0, 1'b0);
        do_dclr(1'b0);
        run_table(-1);
        drain("drain dclr");

        // dclr coincident with the completing strobe cancels that write
        do_dclr(1'b0);
        for (int i = 0; i < 7; i++)
            strobe(tbl[i].din, tbl[i].wr, tbl[i].addr, tbl[i].data,
                   1'b0, 6'd0, 1'b0, 1'b0);
        @(negedge clk);
        dclr = 1'b1; dstrb = 1'b1; din1 = tbl[7].din;
        @(negedge clk);
        dclr = 1'b0; dstrb = 1'b0;
        run_table(-1);
        drain("drain dclr+strobe");

        // async reset mid-line
        do_dclr(1'b0);
        for (int i = 0; i < 5; i++)
            strobe(tbl[i].din, 1'b0, '0, '0, 1'b0, 6'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        check("arst wr_en", 64'(wr_en), 64'd0);
        check("arst wr_addr", 64'(wr_addr), 64'd0);
        check("arst wr_data", 64'(wr_data), 64'd0);
        check("arst mbrow_done", 64'(mbrow_done), 64'd0);
        check("arst frame_done", 64'(frame_done), 64'd0);
        check("arst bank", 64'(bank), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_table(-1);
        drain("drain arst");

        // 4:2:0 mode, three lines
        do_dclr(1'b1);
        for (int y = 0; y < 3; y++) send_line(y, 1'b1, 1'b0);
        drain("drain 420");

        // full frame wrap then first line of next frame
        do_dclr(1'b0);
        for (int y = 0; y < 16; y++) send_line(y, 1'b0, 1'b0);
        drain("drain frame");
        check("bank after wrap", 64'(bank), 64'd1);
        send_line(0, 1'b0, 1'b1);
        drain("drain next frame");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
